carfield_regbus_resp_demux: RTL

- Responder side of the platform RegBus configuration map.
- Accepts single-outstanding register requests from the host RegBus initiator and decodes the address against the four RegBus windows: PCRS, PLL, padframe, L2 ECC.
- Forwards hits to the owning target over a valid/ready handshake and returns the target's response.
- Unmapped, disabled, misaligned or timed-out accesses get a locally generated error response.
- Sits between the host RegBus port and the configuration targets.

---
 rtl/carfield_regbus_resp_demux_pkg.sv | 70 +++++++
 rtl/carfield_regbus_addr_decode.sv | 43 ++++
 rtl/carfield_regbus_resp_demux.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/carfield_regbus_resp_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carfield_regbus_resp_demux_pkg
// Description : Shared types and constants for the RegBus responder demux:
//               target indices, decode windows and enables, locally generated
//               error signatures, FSM state type and request/response structs.
// Revision    : 1.0 - initial release
// ============================================================================
package carfield_regbus_resp_demux_pkg;

    localparam int unsigned NUM_TGT          = 4;
    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned STRB_WIDTH       = DATA_WIDTH / 8;
    localparam int unsigned TGT_OFFSET_WIDTH = 12;

    typedef enum logic [1:0] {
        TGT_PCRS     = 2'd0,
        TGT_PLL      = 2'd1,
        TGT_PADFRAME = 2'd2,
        TGT_L2ECC    = 2'd3
    } tgt_idx_e;

    // Decode rule: base inclusive, base + size exclusive
    typedef struct packed {
        logic [63:0] base;
        logic [63:0] size;
        logic        en;
    } addr_rule_t;

    localparam logic [63:0] WIN_SIZE = 64'h0000_0000_0000_1000;

    localparam logic EN_PCRS     = 1'b1;
    localparam logic EN_PLL      = 1'b1;
    localparam logic EN_PADFRAME = 1'b1;
    localparam logic EN_L2ECC    = 1'b1;

    // Concatenation order places target 3 in the MSB slot, target 0 in the LSB
    localparam addr_rule_t [NUM_TGT-1:0] ADDR_RULES = {
        addr_rule_t'{base: 64'h0000_0000_200B_0000, size: WIN_SIZE, en: EN_L2ECC},
        addr_rule_t'{base: 64'h0000_0000_200A_0000, size: WIN_SIZE, en: EN_PADFRAME},
        addr_rule_t'{base: 64'h0000_0000_2002_0000, size: WIN_SIZE, en: EN_PLL},
        addr_rule_t'{base: 64'h0000_0000_2001_0000, size: WIN_SIZE, en: EN_PCRS}
    };

    localparam logic [DATA_WIDTH-1:0] ERR_DECODE  = 32'hBADC_AB1E;
    localparam logic [DATA_WIDTH-1:0] ERR_TIMEOUT = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Request as forwarded to a target
    typedef struct packed {
        logic [TGT_OFFSET_WIDTH-1:0] offset;
        logic                        write;
        logic [DATA_WIDTH-1:0]       wdata;
        logic [STRB_WIDTH-1:0]       wstrb;
    } tgt_req_t;

    // Response as returned to the host
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  error;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/carfield_regbus_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : carfield_regbus_addr_decode
// Description : Combinational address decoder against a rule array.
//               Ports: addr_i (byte address) -> hit_o, tgt_onehot_o,
//               offset_o (offset in 4 KiB window), misaligned_o.
// Revision    : 1.0 - initial release
// ============================================================================
module carfield_regbus_addr_decode
    import carfield_regbus_resp_demux_pkg::*;
#(
    parameter int unsigned               NumTgt    = NUM_TGT,
    parameter int unsigned               AddrWidth = 48,
    parameter addr_rule_t [NumTgt-1:0]   Rules     = ADDR_RULES
) (
    input  logic [AddrWidth-1:0]        addr_i,
    output logic                        hit_o,
    output logic [NumTgt-1:0]           tgt_onehot_o,
    output logic [TGT_OFFSET_WIDTH-1:0] offset_o,
    output logic                        misaligned_o
);

    logic [63:0] addr_ext;
    assign addr_ext = 64'(addr_i);

    // A disabled rule never matches, so the access falls through as a miss
    always_comb begin
        tgt_onehot_o = '0;
        for (int unsigned k = 0; k < NumTgt; k++) begin
            if (Rules[k].en &&
                (addr_ext >= Rules[k].base) &&
                (addr_ext <  (Rules[k].base + Rules[k].size))) begin
                tgt_onehot_o[k] = 1'b1;
            end
        end
    end

    assign hit_o        = |tgt_onehot_o;
    assign offset_o     = addr_i[TGT_OFFSET_WIDTH-1:0];
    assign misaligned_o = |addr_i[1:0];

endmodule
`default_nettype wire

// File: rtl/carfield_regbus_resp_demux.sv
`default_nettype none
// ============================================================================
// Module      : carfield_regbus_resp_demux
// Description : RegBus responder demux. Accepts one host request at a time,
//               decodes it to PCRS / PLL / padframe / L2 ECC, forwards hits
//               over valid/ready and returns the target response. Misses,
//               misaligned accesses and timeouts get a local error response.
//               Ports: req_* host request, rsp_* host response, tgt_req_*
//               forwarded request, tgt_rsp_* target responses (target k in
//               slice k), err_count_o saturating error-response count.
// Revision    : 1.0 - initial release
// ============================================================================
module carfield_regbus_resp_demux
    import carfield_regbus_resp_demux_pkg::*;
#(
    parameter int unsigned NumTgt        = NUM_TGT,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = DATA_WIDTH,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [AddrWidth-1:0]          req_addr_i,
    input  logic                          req_write_i,
    input  logic [DataWidth-1:0]          req_wdata_i,
    input  logic [DataWidth/8-1:0]        req_wstrb_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_error_o,
    output logic [NumTgt-1:0]             tgt_req_valid_o,
    input  logic [NumTgt-1:0]             tgt_req_ready_i,
    output logic [11:0]                   tgt_addr_o,
    output logic                          tgt_write_o,
    output logic [DataWidth-1:0]          tgt_wdata_o,
    output logic [DataWidth/8-1:0]        tgt_wstrb_o,
    input  logic [NumTgt-1:0]             tgt_rsp_valid_i,
    input  logic [NumTgt*DataWidth-1:0]   tgt_rsp_rdata_i,
    input  logic [NumTgt-1:0]             tgt_rsp_error_i,
    output logic [7:0]                    err_count_o
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles);

    state_e                 state_q;
    logic [NumTgt-1:0]      sel_q;
    tgt_req_t               fwd_q;
    rsp_t                   rsp_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [7:0]             err_cnt_q;
    logic [7:0]             err_cnt_d;

    logic                   dec_hit;
    logic [NumTgt-1:0]      dec_onehot;
    logic [11:0]            dec_offset;
    logic                   dec_misaligned;

    logic                   sel_rsp_valid;
    logic [DataWidth-1:0]   sel_rdata;
    logic                   sel_error;
    logic                   timeout;

    carfield_regbus_addr_decode #(
        .NumTgt    (NumTgt),
        .AddrWidth (AddrWidth)
    ) u_addr_decode (
        .addr_i       (req_addr_i),
        .hit_o        (dec_hit),
        .tgt_onehot_o (dec_onehot),
        .offset_o     (dec_offset),
        .misaligned_o (dec_misaligned)
    );

    // Only the selected target's response lanes are visible to the FSM
    always_comb begin
        sel_rsp_valid = |(tgt_rsp_valid_i & sel_q);
        sel_rdata     = '0;
        sel_error     = 1'b0;
        for (int unsigned k = 0; k < NumTgt; k++) begin
            if (sel_q[k]) begin
                sel_rdata = sel_rdata | tgt_rsp_rdata_i[k*DataWidth +: DataWidth];
                sel_error = sel_error | tgt_rsp_error_i[k];
            end
        end
    end

    // Counter holds the number of FWD/WAIT cycles already elapsed, so the
    // abort takes effect at the end of the TimeoutCycles-th such cycle
    assign timeout = (cnt_q == CntWidth'(TimeoutCycles - 1));

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rsp_valid_o && rsp_ready_i && rsp_q.error && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            fwd_q     <= '0;
            rsp_q     <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        fwd_q.offset <= dec_offset;
                        fwd_q.write  <= req_write_i;
                        fwd_q.wdata  <= req_wdata_i;
                        fwd_q.wstrb  <= req_wstrb_i;
                        sel_q        <= dec_onehot;
                        cnt_q        <= '0;
                        if (dec_hit && !dec_misaligned) begin
                            state_q <= ST_FWD;
                        end else begin
                            rsp_q.rdata <= ERR_DECODE;
                            rsp_q.error <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_FWD: begin
                    cnt_q <= cnt_q + CntWidth'(1);
                    // Abort has priority: a ready in the final cycle would
                    // otherwise leave a WAIT with no budget left
                    if (timeout) begin
                        rsp_q.rdata <= ERR_TIMEOUT;
                        rsp_q.error <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (|(tgt_req_ready_i & sel_q)) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CntWidth'(1);
                    // A response coinciding with the timeout wins
                    if (sel_rsp_valid) begin
                        rsp_q.rdata <= sel_rdata;
                        rsp_q.error <= sel_error;
                        state_q     <= ST_RESP;
                    end else if (timeout) begin
                        rsp_q.rdata <= ERR_TIMEOUT;
                        rsp_q.error <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o     = (state_q == ST_IDLE);
    assign rsp_valid_o     = (state_q == ST_RESP);
    assign rsp_rdata_o     = rsp_q.rdata;
    assign rsp_error_o     = rsp_q.error;
    assign tgt_req_valid_o = (state_q == ST_FWD) ? sel_q : '0;
    assign tgt_addr_o      = fwd_q.offset;
    assign tgt_write_o     = fwd_q.write;
    assign tgt_wdata_o     = fwd_q.wdata;
    assign tgt_wstrb_o     = fwd_q.wstrb;
    assign err_count_o     = err_cnt_q;

endmodule
`default_nettype wire
